// File: rtl/ddr_addr_pkg.sv
// Shared definitions for the DDR frame-buffer address controllers (read and write side).
// Holds the controller state encoding, valid-window bounds and frame-slot address math.
package ddr_addr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2
    } addr_state_t;

    localparam int SLOT_WIDTH  = 5;
    localparam int VALID_START = 4;
    localparam int VALID_END   = 7;

    // Byte address of a slot: word offset (half image block + slot stride) scaled by 4.
    // Full 64-bit result; callers truncate to their address width.
    function automatic logic [63:0] slot_to_addr(
        input logic [SLOT_WIDTH-1:0] slot,
        input logic [31:0]           image_block,
        input logic [31:0]           block_size
    );
        logic [63:0] word_addr;
        word_addr = {33'd0, image_block[31:1]} + ({59'd0, slot} * {32'd0, block_size});
        return word_addr << 2;
    endfunction

endpackage

// File: rtl/frame_slot_sync.sv
// Two-flop bus synchronizer for the writer's frame slot index.
// The writer holds the value for a whole frame, so per-bit skew settles long before use.
module frame_slot_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/rd_frame_addr_ctr.sv
// Read-side DDR frame address controller: one read request per read vsync, on the slot behind the writer.
// Optional WAIT-state watchdog enabled by defining RD_ADDR_TIMEOUT_EN.
module rd_frame_addr_ctr
    import ddr_addr_pkg::*;
#(
    parameter logic [31:0] START_ADDR   = 32'h0004_0000,
    parameter logic [31:0] BLOCK_SIZE   = 32'h0008_0000,
    parameter logic [31:0] IMAGE_BLOCK  = 32'h0007_0800,
    parameter int          FRAME_NUM    = 4,
    parameter logic [31:0] RD_NUM       = 32'd1800,
    parameter int          ADDR_WIDTH   = 30,
    parameter int          RD_NUM_WIDTH = 28,
    parameter int          TIMEOUT_CYC  = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SLOT_WIDTH-1:0]   wr_fram_slot,
    input  logic                    rd_vs,
    input  logic                    rd_ddr_done,
    output logic                    rd_addr_valid,
    output logic [ADDR_WIDTH-1:0]   rd_ddr_addr,
    output logic [RD_NUM_WIDTH-1:0] rd_ddr_num,
    output logic [SLOT_WIDTH-1:0]   rd_fram_slot,
    output logic [SLOT_WIDTH-1:0]   rd_fram_cnt,
    output logic                    rd_repeat,
    output logic                    rd_timeout
);

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT  = SLOT_WIDTH'(FRAME_NUM - 1);
    localparam logic [SLOT_WIDTH-1:0] SLOT_COUNT = SLOT_WIDTH'(FRAME_NUM);

    addr_state_t           state;
    addr_state_t           state_next;
    logic [2:0]            vs_sync;
    logic [2:0]            done_sync;
    logic                  vs_rise;
    logic                  done_rise;
    logic [SLOT_WIDTH-1:0] wr_s;
    logic [SLOT_WIDTH-1:0] sel_slot;
    logic [63:0]           sel_addr_full;
    logic [3:0]            delay_cnt;
    logic                  pending;
    logic [SLOT_WIDTH-1:0] last_slot;
    logic                  start_req;
    logic                  finish_req;
    logic                  to_hit;
    logic                  unused_cfg;

    frame_slot_sync #(
        .WIDTH (SLOT_WIDTH)
    ) u_slot_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (wr_fram_slot),
        .dout (wr_s)
    );

    // Three-stage synchronizers; edges are taken between stages two and three and registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_sync   <= '0;
            done_sync <= '0;
            vs_rise   <= 1'b0;
            done_rise <= 1'b0;
        end else begin
            vs_sync   <= {vs_sync[1:0], rd_vs};
            done_sync <= {done_sync[1:0], rd_ddr_done};
            vs_rise   <= vs_sync[1] & ~vs_sync[2];
            done_rise <= done_sync[1] & ~done_sync[2];
        end
    end

    // Most recently completed slot is the one behind the writer; a corrupt index falls back to slot 0.
    always_comb begin
        sel_slot = '0;
        if (wr_s >= SLOT_COUNT) begin
            sel_slot = '0;
        end else if (wr_s == '0) begin
            sel_slot = LAST_SLOT;
        end else begin
            sel_slot = wr_s - SLOT_WIDTH'(1);
        end
        sel_addr_full = slot_to_addr(sel_slot, IMAGE_BLOCK, BLOCK_SIZE);
    end

    always_comb begin
        state_next = state;
        start_req  = 1'b0;
        finish_req = 1'b0;
        case (state)
            IDLE: begin
                if (vs_rise || pending) begin
                    start_req  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (delay_cnt == 4'(VALID_END)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (done_rise) begin
                    finish_req = 1'b1;
                    state_next = IDLE;
                end else if (to_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request datapath: slot/address/repeat latch on arming, count and history update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cnt    <= '0;
            pending      <= 1'b0;
            last_slot    <= LAST_SLOT;
            rd_fram_slot <= '0;
            rd_ddr_addr  <= '0;
            rd_fram_cnt  <= '0;
            rd_repeat    <= 1'b0;
        end else begin
            if (start_req) begin
                delay_cnt    <= '0;
                rd_fram_slot <= sel_slot;
                rd_ddr_addr  <= sel_addr_full[ADDR_WIDTH-1:0];
                rd_repeat    <= (sel_slot == last_slot);
            end else if (state == SETUP) begin
                delay_cnt <= delay_cnt + 4'd1;
            end

            if (start_req) begin
                pending <= 1'b0;
            end else if (vs_rise) begin
                pending <= 1'b1;
            end

            if (finish_req) begin
                rd_fram_cnt <= rd_fram_cnt + SLOT_WIDTH'(1);
                last_slot   <= rd_fram_slot;
            end
        end
    end

    assign rd_addr_valid = (state == SETUP) &&
                           (delay_cnt >= 4'(VALID_START)) &&
                           (delay_cnt <= 4'(VALID_END));

    assign rd_ddr_num = RD_NUM[RD_NUM_WIDTH-1:0];

`ifdef RD_ADDR_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_hit = (state == WAIT) && (to_cnt == 32'(TIMEOUT_CYC - 1));

    // Watchdog: abandons a WAIT that never sees done; the flag stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt     <= '0;
            rd_timeout <= 1'b0;
        end else begin
            if (state == WAIT) begin
                to_cnt <= to_cnt + 32'd1;
            end else begin
                to_cnt <= '0;
            end
            if (to_hit && !done_rise) begin
                rd_timeout <= 1'b1;
            end
        end
    end
`else
    assign to_hit     = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    assign unused_cfg = ^{START_ADDR, 32'(TIMEOUT_CYC), sel_addr_full[63:ADDR_WIDTH]};

endmodule

// File: doc/rd_frame_addr_ctr.md
Name: rd_frame_addr_ctr

Overview:
- Read-side address controller for the DDR multi-frame buffer. It is the counterpart of the write-side frame address controller.
- On each read vsync it picks the most recently completed frame slot, which is the slot just behind the writer's current slot.
- It issues one read request (address, length, valid window) to the DDR read engine, then waits for the engine's done before arming again.
- It sits between the video output timing generator and the DDR read channel arbiter.

Parameters:
- START_ADDR, 32'h0004_0000, reserved base (not used in address math; kept for map consistency).
- BLOCK_SIZE, 32'h0008_0000, word stride between frame slots.
- IMAGE_BLOCK, 32'h0007_0800, image region size; read base offset = IMAGE_BLOCK/2.
- FRAME_NUM, 4, number of frame slots in rotation (2..31).
- RD_NUM, 32'd1800, burst count per frame request.
- ADDR_WIDTH, 30, byte address width.
- RD_NUM_WIDTH, 28, width of request length.
- TIMEOUT_CYC, 2**20, watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_fram_slot  in  5  slot currently being written; arrives from the writer clock domain
- rd_vs  in  1  read vsync; asynchronous, level
- rd_ddr_done  in  1  read engine done; asynchronous, level
- rd_addr_valid  out  1  request valid window
- rd_ddr_addr  out  ADDR_WIDTH  byte address of frame start
- rd_ddr_num  out  RD_NUM_WIDTH  request length, constant RD_NUM
- rd_fram_slot  out  5  slot being read
- rd_fram_cnt  out  5  completed-read counter, wraps at 32
- rd_repeat  out  1  high when the current slot equals the previous read's slot (writer stalled)
- rd_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, pending 0, last_slot = FRAME_NUM-1. Reset mid-request drops to IDLE at once and clears pending; any done that arrives later is ignored.
- Input synchronisation:
  - rd_vs and rd_ddr_done each pass through 3 flops; a rise is registered (stage1 & ~stage2). Rise detect lags the input by 3 cycles.
  - wr_fram_slot passes through a 2-flop bus synchronizer. The writer holds the value for the whole frame, so no gray coding is needed.
- Slot select, on the IDLE→SETUP transition: slot = (wr_s == 0) ? FRAME_NUM-1 : wr_s-1.
  - If wr_s >= FRAME_NUM (corrupt), use slot 0.
  - rd_repeat = (slot == last_slot). last_slot updates on done.
- Address: rd_ddr_addr = ((IMAGE_BLOCK/2) + slot*BLOCK_SIZE) << 2, truncated to ADDR_WIDTH. It is registered at the IDLE→SETUP transition and held until the next IDLE→SETUP transition.
- FSM:
  - IDLE: on vs_rise or pending → SETUP; latch slot and address; clear pending; clear delay_cnt.
  - SETUP: delay_cnt increments each cycle. rd_addr_valid = 1 while delay_cnt is 4..7 (exactly 4 cycles). When delay_cnt = 7 → WAIT.
  - WAIT: rd_addr_valid = 0. On done_rise → IDLE; rd_fram_cnt increments (mod 32); last_slot updates.
- Pending:
  - A vs_rise in SETUP or WAIT sets pending; multiple rises coalesce into one.
  - vs_rise and done_rise in the same WAIT cycle: go to IDLE with pending = 1, so SETUP follows on the next cycle.
- A done_rise outside WAIT is ignored.
- rd_ddr_num is constant RD_NUM.

Optional Feature:
- Macro RD_ADDR_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - At TIMEOUT_CYC → IDLE; rd_timeout set (sticky until rst); rd_fram_cnt not incremented; last_slot not updated.
- Undefined:
  - WAIT lasts until done.
  - rd_timeout tied 0.
  - No counter logic.

Decomposition:
- Shared package ddr_addr_pkg:
  - state encoding (IDLE = 0, SETUP = 1, WAIT = 2)
  - VALID_START = 4, VALID_END = 7
  - slot width 5
  - address-math function slot_to_addr(slot), shared with the write-side controller
- Sub-module: frame_slot_sync, the 2-flop bus synchronizer, WIDTH parameter.

Test Plan:
1. Reset, wr_fram_slot = 2, rd_vs pulse → 3 cycles later IDLE→SETUP. rd_fram_slot = 1. rd_ddr_addr = (0x38400 + 0x80000) << 2 = 0x2E1000. rd_addr_valid high exactly 4 cycles, cycles 5..8 after the transition.
2. wr_fram_slot = 0 with FRAME_NUM = 4 → slot 3; address = (0x38400 + 3*0x80000) << 2 = 0x6E1000 (masked to 30 bits).
3. Two vs pulses during WAIT, then done → one extra request only; rd_fram_cnt increments by 1 per done.
4. Writer slot held at 2 across two read frames → second request has rd_repeat = 1 and the same address.
5. rst asserted mid-SETUP → valid drops next cycle and outputs return to 0; a later done pulse causes no count change.
6. With RD_ADDR_TIMEOUT_EN and TIMEOUT_CYC = 64, no done → IDLE after 64 WAIT cycles; rd_timeout = 1; rd_fram_cnt unchanged.
